xor_bist_controller: RTL and testbench



---
 rtl/xor_bist_if.sv | 27 ++
 rtl/xor_bist_controller.sv | 130 +++++++++++++
 tb/tb_xor_bist_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_bist_if.sv
// Bus between the XOR BIST controller and its host/unit-under-test: run control,
// operand drive, result return and status.
interface xor_bist_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] dut_result;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [15:0]      vec_count;
  logic [15:0]      fail_count;

  modport master (
    input  start, abort, dut_result,
    output op_a, op_b, busy, done, pass, signature, vec_count, fail_count
  );

  modport slave (
    output start, abort, dut_result,
    input  op_a, op_b, busy, done, pass, signature, vec_count, fail_count
  );
endinterface

// File: rtl/xor_bist_controller.sv
// LFSR-driven BIST engine for a two-operand combinational unit, MISR compaction and golden compare.
// Define XOR_BIST_COMPARE_EN to add per-vector checking against op_a ^ op_b (fail_count).
module xor_bist_controller #(
  parameter int               WIDTH         = 32,
  parameter int               NUM_VECTORS   = 256,
  parameter int               SETTLE_CYCLES = 1,
  parameter logic [WIDTH-1:0] SEED_A        = 32'hFFFF_FFFF,
  parameter logic [WIDTH-1:0] SEED_B        = 32'h5555_5555,
  parameter logic [WIDTH-1:0] GOLDEN_SIG    = 32'hAAAA_AAAA
) (
  input  logic       clk,
  input  logic       rst_n,
  xor_bist_if.master bus
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_SETTLE  | operands held, settle counter running down
  // S_CAPTURE | fold dut_result into MISR, step LFSRs
  // S_DONE    | run complete, pass valid
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [WIDTH-1:0] POLY       = WIDTH'(32'h8020_0003);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? ONE : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? ONE : SEED_B;
  localparam logic [15:0]      LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]       SETTLE_LD  = 4'(SETTLE_CYCLES);

  state_t           state_q, state_nxt;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] op_a_q, op_b_q, sig_q;
  logic [15:0]      vec_count_q;
  logic [15:0]      fail_count_q;
  logic             load_run, do_capture, last_vec;
  logic [WIDTH-1:0] misr_next;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY : '0);
  endfunction

  assign last_vec  = (vec_count_q == LAST_VEC);
  assign misr_next = {sig_q[WIDTH-2:0], ^(sig_q & POLY)} ^ bus.dut_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // abort overrides everything, including a concurrent start or a pending capture
  always_comb begin
    state_nxt  = state_q;
    load_run   = 1'b0;
    do_capture = 1'b0;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            load_run  = 1'b1;
            state_nxt = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt <= 4'd1) state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          do_capture = 1'b1;
          state_nxt  = last_vec ? S_DONE : S_SETTLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      sig_q       <= '0;
      vec_count_q <= '0;
      settle_cnt  <= '0;
    end else begin
      if (load_run) begin
        op_a_q      <= SEED_A_EFF;
        op_b_q      <= SEED_B_EFF;
        sig_q       <= '0;
        vec_count_q <= '0;
      end else if (do_capture) begin
        sig_q  <= misr_next;
        op_a_q <= lfsr_step(op_a_q);
        op_b_q <= lfsr_step(op_b_q);
        if (vec_count_q != 16'hFFFF) vec_count_q <= vec_count_q + 16'd1;
      end

      if (load_run || (do_capture && !last_vec))
        settle_cnt <= SETTLE_LD;
      else if (state_q == S_SETTLE && settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;
    end
  end

`ifdef XOR_BIST_COMPARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count_q <= '0;
    end else if (load_run) begin
      fail_count_q <= '0;
    end else if (do_capture && (bus.dut_result != (op_a_q ^ op_b_q))
                 && fail_count_q != 16'hFFFF) begin
      fail_count_q <= fail_count_q + 16'd1;
    end
  end

  assign bus.pass = (state_q == S_DONE) && (sig_q == GOLDEN_SIG) && (fail_count_q == '0);
`else
  assign fail_count_q = '0;
  assign bus.pass     = (state_q == S_DONE) && (sig_q == GOLDEN_SIG);
`endif

  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.busy       = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.signature  = sig_q;
  assign bus.vec_count  = vec_count_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_xor_bist_controller.sv
// Scoreboard bench for xor_bist_controller: three parameterisations, expected run results
// queued at start and checked by per-instance monitors when done rises.
module tb_xor_bist_controller;

  localparam logic [31:0] POLY = 32'h8020_0003;
`ifdef XOR_BIST_COMPARE_EN
  localparam logic [15:0] ZERO_FC = 16'd1;
`else
  localparam logic [15:0] ZERO_FC = 16'd0;
`endif

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] vc;
    logic [15:0] fc;
    int          e0;
    int          lat;
  } exp_t;

  logic clk, rst_n, zero0;
  int   cyc, checks, errors;
  exp_t q0[$], q1[$], q2[$];
  logic done0_q, done1_q, done2_q;

  xor_bist_if #(.WIDTH(32)) bus0();
  xor_bist_if #(.WIDTH(32)) bus1();
  xor_bist_if #(.WIDTH(32)) bus2();

  assign bus0.dut_result = zero0 ? 32'h0 : (bus0.op_a ^ bus0.op_b);
  assign bus1.dut_result = bus1.op_a ^ bus1.op_b;
  assign bus2.dut_result = bus2.op_a ^ bus2.op_b;

  xor_bist_controller #(.NUM_VECTORS(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  xor_bist_controller #(.NUM_VECTORS(2), .SETTLE_CYCLES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
  xor_bist_controller #(.NUM_VECTORS(8), .SEED_A(32'h0)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_lfsr(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] model_sig(input logic [31:0] sa, input logic [31:0] sb,
                                            input int nv, input bit zero);
    logic [31:0] a, b, s, r;
    a = (sa == 32'h0) ? 32'h1 : sa;
    b = (sb == 32'h0) ? 32'h1 : sb;
    s = 32'h0;
    for (int i = 0; i < nv; i++) begin
      r = zero ? 32'h0 : (a ^ b);
      s = {s[30:0], ^(s & POLY)} ^ r;
      a = tb_lfsr(a);
      b = tb_lfsr(b);
    end
    return s;
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       bus0.start = v;
      1:       bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  // pulses start for one edge (E0); returns at the negedge following E0
  task automatic start_run(input int id);
    @(negedge clk);
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  task automatic push_exp(input int id, input logic [31:0] sig, input logic pass,
                          input logic [15:0] vc, input logic [15:0] fc, input int lat);
    exp_t e;
    e.sig = sig; e.pass = pass; e.vc = vc; e.fc = fc; e.e0 = cyc; e.lat = lat;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_done(input int id, input int bound);
    int n = 0;
    while (!get_done(id) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_done_in_time", id), {31'h0, get_done(id)}, 32'h1);
  endtask

  task automatic compare_run(input string tag, input exp_t e, input logic [31:0] sig,
                             input logic pass, input logic [15:0] vc, input logic [15:0] fc);
    check({tag, "_signature"}, sig, e.sig);
    check({tag, "_pass"}, {31'h0, pass}, {31'h0, e.pass});
    check({tag, "_vec_count"}, {16'h0, vc}, {16'h0, e.vc});
    check({tag, "_fail_count"}, {16'h0, fc}, {16'h0, e.fc});
    check({tag, "_latency"}, 32'(cyc - e.e0), 32'(e.lat));
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done: got done=1 expected no run pending", tag);
  endtask

  always @(negedge clk) begin
    if (bus0.done && !done0_q) begin
      if (q0.size() == 0) unexpected("u0");
      else compare_run("u0", q0.pop_front(), bus0.signature, bus0.pass, bus0.vec_count, bus0.fail_count);
    end
    if (bus1.done && !done1_q) begin
      if (q1.size() == 0) unexpected("u1");
      else compare_run("u1", q1.pop_front(), bus1.signature, bus1.pass, bus1.vec_count, bus1.fail_count);
    end
    if (bus2.done && !done2_q) begin
      if (q2.size() == 0) unexpected("u2");
      else compare_run("u2", q2.pop_front(), bus2.signature, bus2.pass, bus2.vec_count, bus2.fail_count);
    end
    done0_q = bus0.done;
    done1_q = bus1.done;
    done2_q = bus2.done;
  end

  initial begin
    logic [31:0] s;
    int          busy_n;
    bit          seen;
    int          n;
    checks = 0; errors = 0;
    done0_q = 1'b0; done1_q = 1'b0; done2_q = 1'b0;
    rst_n = 1'b0; zero0 = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_op_a", bus0.op_a, 32'h0);
    check("rst_op_b", bus0.op_b, 32'h0);
    check("rst_flags", {29'h0, bus0.busy, bus0.done, bus0.pass}, 32'h0);
    check("rst_counts", {bus1.vec_count, bus1.fail_count}, 32'h0);
    check("rst_signature", bus2.signature, 32'h0);
    rst_n = 1'b1;

    // single vector, correct XOR unit
    start_run(0);
    push_exp(0, 32'hAAAA_AAAA, 1'b1, 16'd1, 16'd0, 2);
    check("a_op_a", bus0.op_a, 32'hFFFF_FFFF);
    check("a_op_b", bus0.op_b, 32'h5555_5555);
    check("a_result", bus0.dut_result, 32'hAAAA_AAAA);
    check("a_busy", {31'h0, bus0.busy}, 32'h1);
    wait_done(0, 20);
    repeat (3) @(negedge clk);
    check("a_done_hold", {30'h0, bus0.done, bus0.pass}, 32'h3);

    // single vector, broken unit returning 0
    zero0 = 1'b1;
    start_run(0);
    push_exp(0, 32'h0, 1'b0, 16'd1, ZERO_FC, 2);
    wait_done(0, 20);
    zero0 = 1'b0;

    // two vectors, two settle cycles
    start_run(1);
    s = model_sig(32'hFFFF_FFFF, 32'h5555_5555, 2, 1'b0);
    push_exp(1, s, s == 32'hAAAA_AAAA, 16'd2, 16'd0, 6);
    busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !bus1.done; i++) begin
      if (bus1.busy) busy_n++;
      if (bus1.vec_count == 16'd1 && !seen) begin
        seen = 1'b1;
        check("b_vec2_op_a", bus1.op_a, 32'hFFDF_FFFC);
        check("b_vec2_op_b", bus1.op_b, 32'hAA8A_AAA9);
      end
      @(negedge clk);
    end
    check("b_vec2_seen", {31'h0, seen}, 32'h1);
    check("b_busy_cycles", 32'(busy_n), 32'd6);
    wait_done(1, 5);

    // zero seed, start while busy, abort mid-run
    start_run(2);
    check("c_seed_zero_op_a", bus2.op_a, 32'h0000_0001);
    check("c_op_b", bus2.op_b, 32'h5555_5555);
    n = 0;
    while (bus2.vec_count != 16'd2 && n < 40) begin @(negedge clk); n++; end
    check("c_reach_vec2", {16'h0, bus2.vec_count}, 32'd2);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    check("c_busy_start_ignored", {15'h0, bus2.busy, bus2.vec_count}, {15'h0, 1'b1, 16'd2});
    n = 0;
    while (bus2.vec_count != 16'd3 && n < 40) begin @(negedge clk); n++; end
    check("c_reach_vec3", {16'h0, bus2.vec_count}, 32'd3);
    bus2.abort = 1'b1;
    @(negedge clk);
    bus2.abort = 1'b0;
    check("c_abort_flags", {30'h0, bus2.busy, bus2.done}, 32'h0);
    check("c_abort_vec_count", {16'h0, bus2.vec_count}, 32'd3);
    start_run(2);
    check("c_restart_vec_count", {16'h0, bus2.vec_count}, 32'd0);
    check("c_restart_signature", bus2.signature, 32'h0);
    s = model_sig(32'h0, 32'h5555_5555, 8, 1'b0);
    push_exp(2, s, s == 32'hAAAA_AAAA, 16'd8, 16'd0, 16);
    wait_done(2, 40);

    // asynchronous reset between edges during SETTLE
    start_run(0);
    #2 rst_n = 1'b0;
    #1;
    check("d_async_op_a", bus0.op_a, 32'h0);
    check("d_async_busy", {31'h0, bus0.busy}, 32'h0);
    check("d_async_u2_vec_count", {16'h0, bus2.vec_count}, 32'd0);
    check("d_async_u2_flags", {30'h0, bus2.done, bus2.pass}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(0);
    push_exp(0, 32'hAAAA_AAAA, 1'b1, 16'd1, 16'd0, 2);
    wait_done(0, 20);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
